// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per clock over operand magnitudes,
// followed by a sign-correction cycle; divide-by-zero and signed overflow resolve at accept.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            MDctrl,
    input  logic [DATA_WIDTH-1:0] MDop1,
    input  logic [DATA_WIDTH-1:0] MDop2,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] RESULT
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      ctrl_q, ctrl_d;
    logic            neg_q, neg_d;
    logic [W-1:0]    addend_q, addend_d;
    logic [2*W-1:0]  work_q, work_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    result_q, result_d;

    // Operand decode for the request presented this cycle
    logic         in_div, sgn1, sgn2, div_zero, div_ovf;
    logic [W-1:0] mag1, mag2, min_neg;

    assign in_div   = MDctrl[2];
    assign sgn1     = MDop1[W-1] & ((MDctrl == 3'b001) | (MDctrl == 3'b010) |
                                    (MDctrl == 3'b100) | (MDctrl == 3'b110));
    assign sgn2     = MDop2[W-1] & ((MDctrl == 3'b001) | (MDctrl == 3'b100) |
                                    (MDctrl == 3'b110));
    assign mag1     = sgn1 ? (~MDop1 + 1'b1) : MDop1;
    assign mag2     = sgn2 ? (~MDop2 + 1'b1) : MDop2;
    assign min_neg  = {1'b1, {(W-1){1'b0}}};
    assign div_zero = in_div & (MDop2 == '0);
    assign div_ovf  = in_div & ~MDctrl[0] & (MDop1 == min_neg) & (MDop2 == '1);

    // Multiply step: conditionally add multiplicand to the high half, then shift right.
    // The low half starts as the multiplier and is consumed one bit per step.
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    assign mul_sum  = {1'b0, work_q[2*W-1:W]} + (work_q[0] ? {1'b0, addend_q} : {(W+1){1'b0}});
    assign mul_next = {mul_sum, work_q[W-1:1]};

    // Restoring divide step: high half is the partial remainder, low half shifts the
    // dividend out and the quotient in. Bit W of the difference is the borrow.
    logic [W:0]     div_sh, div_diff;
    logic [2*W-1:0] div_next;
    assign div_sh   = {work_q[2*W-1:W], work_q[W-1]};
    assign div_diff = div_sh - {1'b0, addend_q};
    assign div_next = div_diff[W] ? {div_sh[W-1:0],   work_q[W-2:0], 1'b0}
                                  : {div_diff[W-1:0], work_q[W-2:0], 1'b1};

    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix, rem_fix;
    assign prod_fix = neg_q ? (~work_q + 1'b1) : work_q;
    assign quo_fix  = neg_q ? (~work_q[W-1:0] + 1'b1) : work_q[W-1:0];
    assign rem_fix  = neg_q ? (~work_q[2*W-1:W] + 1'b1) : work_q[2*W-1:W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ctrl_q   <= '0;
            neg_q    <= 1'b0;
            addend_q <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            neg_q    <= neg_d;
            addend_q <= addend_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        neg_d    = neg_q;
        addend_d = addend_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ready    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                ready = 1'b1;
                done  = (state_q == DONE);
                if (start) begin
                    ctrl_d = MDctrl;
                    // REM takes the dividend's sign; all other signed ops take the product sign
                    neg_d  = (MDctrl == 3'b110) ? sgn1 : (sgn1 ^ sgn2);
                    cnt_d  = '0;
                    if (div_zero) begin
                        result_d = MDctrl[1] ? MDop1 : '1;
                        state_d  = DONE;
                    end else if (div_ovf) begin
                        result_d = MDctrl[1] ? '0 : min_neg;
                        state_d  = DONE;
                    end else begin
                        addend_d = in_div ? mag2 : mag1;
                        work_d   = {{W{1'b0}}, (in_div ? mag1 : mag2)};
                        state_d  = CALC;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                busy   = 1'b1;
                work_d = ctrl_q[2] ? div_next : mul_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(W-1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                busy = 1'b1;
                case (ctrl_q)
                    3'b000:                 result_d = prod_fix[W-1:0];
                    3'b001, 3'b010, 3'b011: result_d = prod_fix[2*W-1:W];
                    3'b100, 3'b101:         result_d = quo_fix;
                    default:                result_d = rem_fix;
                endcase
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign RESULT = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table at 32 bits, hand sequences for
// ignored start, back-to-back accept, mid-operation reset, and an 8-bit instance.
module tb_muldiv_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic [2:0]  ctrl;
    logic [31:0] op1, op2;
    logic        ready, busy, done;
    logic [31:0] result;

    logic        start8;
    logic [2:0]  ctrl8;
    logic [7:0]  op1_8, op2_8;
    logic        ready8, busy8, done8;
    logic [7:0]  result8;

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .MDctrl(ctrl), .MDop1(op1), .MDop2(op2),
        .ready(ready), .busy(busy), .done(done), .RESULT(result)
    );

    muldiv_unit #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .MDctrl(ctrl8), .MDop1(op1_8), .MDop2(op2_8),
        .ready(ready8), .busy(busy8), .done(done8), .RESULT(result8)
    );

    typedef struct {
        logic [2:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h want 0x%h", name, act, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output logic hs_ok);
        @(negedge clk);
        ctrl = c; op1 = a; op2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1; hs_ok = 1'b1;
        while (!done && lat < 100) begin
            if (ready || !busy) hs_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        res = result;
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        logic        hs_ok;
        logic        held_ok;
        int          spur;

        rst = 1'b1; start = 1'b0; ctrl = '0; op1 = '0; op2 = '0;
        start8 = 1'b0; ctrl8 = '0; op1_8 = '0; op2_8 = '0;

        vecs.push_back('{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34});
        vecs.push_back('{3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 34});
        vecs.push_back('{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34});
        vecs.push_back('{3'b001, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 34});
        vecs.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34});
        vecs.push_back('{3'b011, 32'h80000000, 32'd4,        32'h00000002, 34});
        vecs.push_back('{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34});
        vecs.push_back('{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34});
        vecs.push_back('{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34});
        vecs.push_back('{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34});
        vecs.push_back('{3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 34});
        vecs.push_back('{3'b101, 32'hFFFFFFFE, 32'd3,        32'h55555554, 34});
        vecs.push_back('{3'b111, 32'hFFFFFFFE, 32'd3,        32'h00000002, 34});
        vecs.push_back('{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1});
        vecs.push_back('{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1});
        vecs.push_back('{3'b111, 32'd5,        32'd0,        32'h00000005, 1});
        vecs.push_back('{3'b110, 32'd5,        32'd0,        32'h00000005, 1});
        vecs.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
        vecs.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});

        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("reset_ready", {31'b0, ready}, 32'd1);
        check("reset_busy",  {31'b0, busy},  32'd0);
        check("reset_done",  {31'b0, done},  32'd0);
        check("reset_result", result, 32'd0);
        check("reset8_ready", {31'b0, ready8}, 32'd1);
        check("reset8_result", {24'b0, result8}, 32'd0);

        foreach (vecs[i]) begin
            do_op(vecs[i].c, vecs[i].a, vecs[i].b, res, lat, hs_ok);
            $display("op %0d ctrl=%0d a=%h b=%h result=%h lat=%0d", i, vecs[i].c,
                     vecs[i].a, vecs[i].b, res, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_handshake", i), {31'b0, hs_ok}, 32'd1);
            check($sformatf("vec%0d_ready_in_done", i), {31'b0, ready}, 32'd1);
            @(posedge clk); #1;
            check($sformatf("vec%0d_done_single", i), {31'b0, done}, 32'd0);
        end

        // start pulse and operand change during CALC must not disturb the operation
        @(negedge clk);
        ctrl = 3'b101; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; lat = 1;
        repeat (5) begin @(posedge clk); #1; lat++; end
        @(negedge clk);
        start = 1'b1; ctrl = 3'b000; op1 = 32'd200;
        @(posedge clk); #1;
        lat++; start = 1'b0; op1 = 32'd999;
        while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
        $display("op ignored-start DIVU 100/7 result=%h lat=%0d", result, lat);
        check("ignore_result", result, 32'd14);
        check("ignore_latency", 32'(lat), 32'd34);

        // back-to-back accept in the DONE cycle; previous result held until reload
        @(negedge clk);
        ctrl = 3'b000; op1 = 32'd3; op2 = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; lat = 1; held_ok = 1'b1;
        while (!done && lat < 100) begin
            if (result !== 32'd14) held_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        $display("op back-to-back MUL 3x4 result=%h lat=%0d", result, lat);
        check("b2b_held", {31'b0, held_ok}, 32'd1);
        check("b2b_result", result, 32'd12);
        check("b2b_latency", 32'(lat), 32'd34);
        @(posedge clk); #1;

        // reset during iteration 10 of a DIVU
        @(negedge clk);
        ctrl = 3'b101; op1 = 32'hFFFFFFFE; op2 = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2; rst = 1'b1; #1;
        $display("op reset mid-DIVU ready=%0d busy=%0d done=%0d result=%h", ready, busy, done, result);
        check("abort_ready",  {31'b0, ready}, 32'd1);
        check("abort_busy",   {31'b0, busy},  32'd0);
        check("abort_done",   {31'b0, done},  32'd0);
        check("abort_result", result, 32'd0);
        @(negedge clk); rst = 1'b0;
        spur = 0;
        repeat (40) begin @(posedge clk); #1; if (done) spur++; end
        check("abort_no_done", 32'(spur), 32'd0);

        do_op(3'b101, 32'hFFFFFFFE, 32'd3, res, lat, hs_ok);
        $display("op post-reset DIVU result=%h lat=%0d", res, lat);
        check("post_reset_result", res, 32'h55555554);
        check("post_reset_latency", 32'(lat), 32'd34);

        // 8-bit instance: MULHU 0xFF x 0xFF
        @(negedge clk);
        ctrl8 = 3'b011; op1_8 = 8'hFF; op2_8 = 8'hFF; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; lat = 1;
        while (!done8 && lat < 100) begin @(posedge clk); #1; lat++; end
        $display("op w8 MULHU ff*ff result=%h lat=%0d", result8, lat);
        check("w8_result", {24'b0, result8}, 32'h000000FE);
        check("w8_latency", 32'(lat), 32'd10);
        @(posedge clk); #1;
        check("w8_done_single", {31'b0, done8}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
